tour_move_encoder: RTL and testbench

- Responder and encoder at the far end of the tour command interface. Sits where the command processor would sit and consumes the 16-bit cmd/cmd_rdy stream produced from tour moves.
- Performs the clr_cmd_rdy/send_resp handshake with a programmable execution delay.
- Pairs each horizontal command with the following vertical command and re-encodes the pair into the 8-bit one-hot knight move. Writes the move to a move log, tracks knight position on the 5x5 board, and flags protocol errors.
- Used as a stand-in responder and checker in system benches, and as an on-chip tour recorder.

---
 rtl/tour_pkg.sv | 73 +++++++
 rtl/tour_move_encoder_move_encode.sv | 37 +++
 rtl/tour_move_encoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_tour_move_encoder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// -----------------------------------------------------------------------------
// tour_pkg
// Shared definitions for the tour command interface:
//   - opcode and heading constants of the 16-bit move command
//     {opcode[15:12], heading[11:4], squares[3:0]}
//   - response codes returned by the command processor
//   - one-hot knight move encoding
//   - responder FSM state type
//   - decode_cmd(): classifies a command and yields its signed displacement
// -----------------------------------------------------------------------------
package tour_pkg;

    localparam logic [3:0] OPC_MOVE_A = 4'h2;
    localparam logic [3:0] OPC_MOVE_B = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // Knight move as (dx,dy); names read as <x dir><x steps><y dir><y steps>
    typedef enum logic [7:0] {
        MV_NONE = 8'h00,
        MV_W1N2 = 8'h01,   // (-1,+2)
        MV_E1N2 = 8'h02,   // (+1,+2)
        MV_W2N1 = 8'h04,   // (-2,+1)
        MV_W2S1 = 8'h08,   // (-2,-1)
        MV_W1S2 = 8'h10,   // (-1,-2)
        MV_E1S2 = 8'h20,   // (+1,-2)
        MV_E2S1 = 8'h40,   // (+2,-1)
        MV_E2N1 = 8'h80    // (+2,+1)
    } move_t;

    typedef enum logic [2:0] {
        WAIT_H,
        EXEC_H,
        WAIT_V,
        EXEC_V,
        WRITE
    } state_t;

    typedef struct packed {
        logic       bad;    // illegal opcode, heading or squares
        logic       horiz;  // heading is east or west
        logic       vert;   // heading is north or south
        logic [3:0] delta;  // signed displacement, zero when bad
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [15:0] c);
        cmd_dec_t d;
        logic     op_ok;
        logic     sq_ok;
        logic     neg;
        op_ok   = (c[15:12] == OPC_MOVE_A) || (c[15:12] == OPC_MOVE_B);
        sq_ok   = (c[3:0] == 4'd1) || (c[3:0] == 4'd2);
        d.horiz = (c[11:4] == HDG_E) || (c[11:4] == HDG_W);
        d.vert  = (c[11:4] == HDG_N) || (c[11:4] == HDG_S);
        neg     = (c[11:4] == HDG_W) || (c[11:4] == HDG_S);
        d.bad   = !op_ok || !sq_ok || !(d.horiz || d.vert);
        if (d.bad) begin
            d.delta = '0;
        end else if (neg) begin
            d.delta = 4'd0 - c[3:0];
        end else begin
            d.delta = c[3:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/tour_move_encoder_move_encode.sv
// -----------------------------------------------------------------------------
// move_encode
// Combinational map from a signed (dx,dy) displacement to the one-hot knight
// move code. Anything that is not one of the eight knight moves returns
// o_onehot = 0 and o_illegal = 1.
// Ports:
//   i_dx      in  4  signed column displacement
//   i_dy      in  4  signed row displacement
//   o_onehot  out 8  one-hot move code
//   o_illegal out 1  displacement is not a knight move
// -----------------------------------------------------------------------------
module move_encode
    import tour_pkg::*;
(
    input  logic [3:0] i_dx,
    input  logic [3:0] i_dy,
    output logic [7:0] o_onehot,
    output logic       o_illegal
);

    always_comb begin
        o_onehot  = MV_NONE;
        o_illegal = 1'b0;
        case ({i_dx, i_dy})
            8'hF2:   o_onehot = MV_W1N2;
            8'h12:   o_onehot = MV_E1N2;
            8'hE1:   o_onehot = MV_W2N1;
            8'hEF:   o_onehot = MV_W2S1;
            8'hFE:   o_onehot = MV_W1S2;
            8'h1E:   o_onehot = MV_E1S2;
            8'h2F:   o_onehot = MV_E2S1;
            8'h21:   o_onehot = MV_E2N1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tour_move_encoder.sv
// -----------------------------------------------------------------------------
// tour_move_encoder
// Far-end responder of the tour command interface. Accepts a horizontal then a
// vertical move command, completes the clr_cmd_rdy/send_resp handshake for
// each after EXEC_CYCLES+1 cycles, re-encodes the pair as a one-hot knight
// move, logs it, tracks the knight position and raises sticky error flags.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   arm             restart pulse (honoured only while waiting for a horizontal)
//   cmd, cmd_rdy    incoming command and valid
//   clr_cmd_rdy     one-cycle accept pulse
//   send_resp       one-cycle completion pulse
//   resp            processor response, sampled with the vertical send_resp
//   move_wr         log write strobe
//   move_out        encoded move, 8'h00 when the pair had any error
//   wr_indx         log address of move_out
//   pos_x, pos_y    knight position
//   err_seq, err_cmd, err_move, err_bound  sticky error flags
//   tour_done       sticky: processor reported end of tour
// -----------------------------------------------------------------------------
module tour_move_encoder
    import tour_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 4,
    parameter int unsigned NUM_MOVES   = 24,
    parameter int unsigned X0          = 2,
    parameter int unsigned Y0          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    input  logic [7:0]  resp,
    output logic        move_wr,
    output logic [7:0]  move_out,
    output logic [4:0]  wr_indx,
    output logic [2:0]  pos_x,
    output logic [2:0]  pos_y,
    output logic        err_seq,
    output logic        err_cmd,
    output logic        err_move,
    output logic        err_bound,
    output logic        tour_done
);

    localparam logic [7:0] EXEC_LAST = 8'(EXEC_CYCLES);
    localparam logic [4:0] LAST_IDX  = 5'(NUM_MOVES - 1);
    localparam logic [2:0] X_START   = 3'(X0);
    localparam logic [2:0] Y_START   = 3'(Y0);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [3:0] r_dx;
    logic [3:0] r_dy;
    logic [3:0] r_sq_h;
    logic       r_pair_err;
    logic       r_resp_done;
    logic [4:0] r_wr_indx;
    logic [2:0] r_pos_x;
    logic [2:0] r_pos_y;
    logic       r_err_seq;
    logic       r_err_cmd;
    logic       r_err_move;
    logic       r_err_bound;
    logic       r_tour_done;

    cmd_dec_t   w_dec_in;
    logic       w_exec_last;
    logic       w_sq_pair_ok;
    logic [3:0] w_sum_x;
    logic [3:0] w_sum_y;
    logic       w_lo_x;
    logic       w_hi_x;
    logic       w_lo_y;
    logic       w_hi_y;
    logic [2:0] w_new_x;
    logic [2:0] w_new_y;
    logic       w_bound_err;
    logic       w_idx_err;
    logic       w_write_err;
    logic [7:0] w_onehot;
    logic       w_enc_illegal;

    assign w_dec_in    = decode_cmd(cmd);
    assign w_exec_last = (r_cnt == EXEC_LAST);

    // Squares of the pair must be {1,2} or {2,1}; checked when the vertical
    // command is latched, against the stored horizontal squares.
    assign w_sq_pair_ok = ((r_sq_h == 4'd1) && (cmd[3:0] == 4'd2)) ||
                          ((r_sq_h == 4'd2) && (cmd[3:0] == 4'd1));

    // Position step in 4-bit two's complement: range -2..6 never overflows
    assign w_sum_x = {1'b0, r_pos_x} + r_dx;
    assign w_sum_y = {1'b0, r_pos_y} + r_dy;
    assign w_lo_x  = w_sum_x[3];
    assign w_hi_x  = !w_sum_x[3] && (w_sum_x[2:0] > 3'd4);
    assign w_lo_y  = w_sum_y[3];
    assign w_hi_y  = !w_sum_y[3] && (w_sum_y[2:0] > 3'd4);
    assign w_new_x = w_lo_x ? 3'd0 : (w_hi_x ? 3'd4 : w_sum_x[2:0]);
    assign w_new_y = w_lo_y ? 3'd0 : (w_hi_y ? 3'd4 : w_sum_y[2:0]);
    assign w_bound_err = w_lo_x | w_hi_x | w_lo_y | w_hi_y;

    // End-of-tour response must coincide exactly with the last log slot
    assign w_idx_err = r_resp_done != (r_wr_indx == LAST_IDX);

    assign w_write_err = r_pair_err | w_bound_err | w_idx_err | w_enc_illegal;

    move_encode u_move_encode (
        .i_dx      (r_dx),
        .i_dy      (r_dy),
        .o_onehot  (w_onehot),
        .o_illegal (w_enc_illegal)
    );

    always_comb begin
        w_next      = r_state;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        move_wr     = 1'b0;
        move_out    = '0;
        case (r_state)
            WAIT_H: begin
                if (!arm && cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    w_next      = EXEC_H;
                end
            end
            EXEC_H: begin
                if (w_exec_last) begin
                    send_resp = 1'b1;
                    w_next    = WAIT_V;
                end
            end
            WAIT_V: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    w_next      = EXEC_V;
                end
            end
            EXEC_V: begin
                if (w_exec_last) begin
                    send_resp = 1'b1;
                    w_next    = WRITE;
                end
            end
            WRITE: begin
                move_wr  = 1'b1;
                move_out = w_write_err ? 8'h00 : w_onehot;
                w_next   = WAIT_H;
            end
            default: w_next = WAIT_H;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_H;
            r_cnt       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_sq_h      <= '0;
            r_pair_err  <= 1'b0;
            r_resp_done <= 1'b0;
            r_wr_indx   <= '0;
            r_pos_x     <= X_START;
            r_pos_y     <= Y_START;
            r_err_seq   <= 1'b0;
            r_err_cmd   <= 1'b0;
            r_err_move  <= 1'b0;
            r_err_bound <= 1'b0;
            r_tour_done <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                WAIT_H: begin
                    r_cnt <= '0;
                    if (arm) begin
                        r_wr_indx   <= '0;
                        r_pos_x     <= X_START;
                        r_pos_y     <= Y_START;
                        r_err_seq   <= 1'b0;
                        r_err_cmd   <= 1'b0;
                        r_err_move  <= 1'b0;
                        r_err_bound <= 1'b0;
                        r_tour_done <= 1'b0;
                    end else if (cmd_rdy) begin
                        // Only the decoded displacement is kept; a wrong-axis
                        // heading contributes no motion.
                        r_dx       <= w_dec_in.horiz ? w_dec_in.delta : 4'd0;
                        r_sq_h     <= cmd[3:0];
                        r_pair_err <= w_dec_in.vert | w_dec_in.bad;
                        if (w_dec_in.vert) r_err_seq <= 1'b1;
                        if (w_dec_in.bad)  r_err_cmd <= 1'b1;
                    end
                end
                EXEC_H: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                WAIT_V: begin
                    r_cnt <= '0;
                    if (cmd_rdy) begin
                        r_dy       <= w_dec_in.vert ? w_dec_in.delta : 4'd0;
                        r_pair_err <= r_pair_err | w_dec_in.horiz |
                                      w_dec_in.bad | !w_sq_pair_ok;
                        if (w_dec_in.horiz) r_err_seq  <= 1'b1;
                        if (w_dec_in.bad)   r_err_cmd  <= 1'b1;
                        if (!w_sq_pair_ok)  r_err_move <= 1'b1;
                    end
                end
                EXEC_V: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_exec_last) begin
                        r_resp_done <= (resp == RESP_DONE);
                        if (resp == RESP_DONE) r_tour_done <= 1'b1;
                    end
                end
                WRITE: begin
                    r_pos_x <= w_new_x;
                    r_pos_y <= w_new_y;
                    if (w_bound_err) r_err_bound <= 1'b1;
                    if (w_idx_err)   r_err_seq   <= 1'b1;
                    r_wr_indx <= (r_wr_indx == LAST_IDX) ? 5'd0 : r_wr_indx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign wr_indx   = r_wr_indx;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign err_seq   = r_err_seq;
    assign err_cmd   = r_err_cmd;
    assign err_move  = r_err_move;
    assign err_bound = r_err_bound;
    assign tour_done = r_tour_done;

endmodule

// File: tb/tb_tour_move_encoder.sv
// -----------------------------------------------------------------------------
// tb_tour_move_encoder
// Directed scenarios, a full open knight's tour found by search, and random
// command pairs, all compared against a behavioural model of the board,
// flags and log index.
// -----------------------------------------------------------------------------
module tb_tour_move_encoder;
    import tour_pkg::*;

    localparam int EXEC = 4;
    localparam int NMOV = 24;
    localparam int SX   = 2;
    localparam int SY   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        move_wr;
    logic [7:0]  move_out;
    logic [4:0]  wr_indx;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic        err_seq;
    logic        err_cmd;
    logic        err_move;
    logic        err_bound;
    logic        tour_done;

    tour_move_encoder #(
        .EXEC_CYCLES (EXEC),
        .NUM_MOVES   (NMOV),
        .X0          (SX),
        .Y0          (SY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .move_wr     (move_wr),
        .move_out    (move_out),
        .wr_indx     (wr_indx),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .err_seq     (err_seq),
        .err_cmd     (err_cmd),
        .err_move    (err_move),
        .err_bound   (err_bound),
        .tour_done   (tour_done)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (clr_cmd_rdy === 1'b1 && send_resp === 1'b1) overlap++;
    end

    // ---------------- reference model ----------------
    int kdx[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int kdy[8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};
    int tour_k[24];

    int m_x, m_y, m_idx;
    bit m_seq, m_cmd, m_move, m_bound, m_done;

    function automatic int axis_of(input logic [7:0] hd);
        if (hd == HDG_E || hd == HDG_W) return 1;
        if (hd == HDG_N || hd == HDG_S) return 2;
        return 0;
    endfunction

    function automatic int sign_of(input logic [7:0] hd);
        return (hd == HDG_W || hd == HDG_S) ? -1 : 1;
    endfunction

    function automatic bit legal(input logic [15:0] c);
        logic [3:0] op;
        logic [3:0] sq;
        op = c[15:12];
        sq = c[3:0];
        return (op == 4'h2 || op == 4'h3) && axis_of(c[11:4]) != 0 && (sq == 4'd1 || sq == 4'd2);
    endfunction

    task automatic model_reset();
        m_x = SX; m_y = SY; m_idx = 0;
        m_seq = 0; m_cmd = 0; m_move = 0; m_bound = 0; m_done = 0;
    endtask

    task automatic model_pair(input logic [15:0] h, input logic [15:0] v, input logic [7:0] rsp,
                              output logic [7:0] mv, output int idx);
        bit bad;
        int dx, dy, sh, sv, nx, ny;
        bad = 0; dx = 0; dy = 0;
        sh = int'(h[3:0]);
        sv = int'(v[3:0]);
        if (axis_of(h[11:4]) == 2) begin m_seq = 1; bad = 1; end
        if (!legal(h))             begin m_cmd = 1; bad = 1; end
        if (axis_of(v[11:4]) == 1) begin m_seq = 1; bad = 1; end
        if (!legal(v))             begin m_cmd = 1; bad = 1; end
        if (!((sh == 1 && sv == 2) || (sh == 2 && sv == 1))) begin m_move = 1; bad = 1; end
        if (legal(h) && axis_of(h[11:4]) == 1) dx = sign_of(h[11:4]) * sh;
        if (legal(v) && axis_of(v[11:4]) == 2) dy = sign_of(v[11:4]) * sv;
        if (rsp == RESP_DONE) m_done = 1;
        if ((rsp == RESP_DONE) != (m_idx == NMOV - 1)) begin m_seq = 1; bad = 1; end
        nx = m_x + dx;
        ny = m_y + dy;
        if (nx < 0) begin nx = 0; m_bound = 1; bad = 1; end
        else if (nx > 4) begin nx = 4; m_bound = 1; bad = 1; end
        if (ny < 0) begin ny = 0; m_bound = 1; bad = 1; end
        else if (ny > 4) begin ny = 4; m_bound = 1; bad = 1; end
        mv = 8'h00;
        if (!bad) begin
            for (int k = 0; k < 8; k++) begin
                if (kdx[k] == dx && kdy[k] == dy) mv[k] = 1'b1;
            end
        end
        idx   = m_idx;
        m_idx = (m_idx + 1) % NMOV;
        m_x   = nx;
        m_y   = ny;
    endtask

    function automatic logic [15:0] hcmd(input int k);
        int d;
        d = kdx[k];
        return {OPC_MOVE_A, (d > 0) ? HDG_E : HDG_W, 4'((d > 0) ? d : -d)};
    endfunction

    function automatic logic [15:0] vcmd(input int k);
        int d;
        d = kdy[k];
        return {OPC_MOVE_B, (d > 0) ? HDG_N : HDG_S, 4'((d > 0) ? d : -d)};
    endfunction

    // Depth-first search for an open tour from the start square
    task automatic find_tour(output bit ok);
        bit vis[5][5];
        int px[25], py[25], nxt[25], mvk[25];
        int d, k, nx, ny, iter;
        bit adv;
        for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) vis[a][b] = 0;
        px[0] = SX; py[0] = SY; vis[SX][SY] = 1; nxt[0] = 0; d = 0; iter = 0;
        k = 0; nx = 0; ny = 0;
        while (d >= 0 && d < 24 && iter < 5000000) begin
            iter++;
            adv = 0;
            for (int j = nxt[d]; j < 8; j++) begin
                if (!adv) begin
                    nx = px[d] + kdx[j];
                    ny = py[d] + kdy[j];
                    if (nx >= 0 && nx <= 4 && ny >= 0 && ny <= 4) begin
                        if (!vis[nx][ny]) begin adv = 1; k = j; end
                    end
                end
            end
            if (adv) begin
                nx = px[d] + kdx[k];
                ny = py[d] + kdy[k];
                nxt[d] = k + 1; mvk[d] = k;
                d++;
                px[d] = nx; py[d] = ny; vis[nx][ny] = 1; nxt[d] = 0;
            end else begin
                vis[px[d]][py[d]] = 0;
                d--;
            end
        end
        ok = (d == 24);
        for (int i = 0; i < 24; i++) tour_k[i] = ok ? mvk[i] : 0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":pos_x"},     pos_x,     m_x);
        check({tag, ":pos_y"},     pos_y,     m_y);
        check({tag, ":wr_indx"},   wr_indx,   m_idx);
        check({tag, ":err_seq"},   err_seq,   m_seq);
        check({tag, ":err_cmd"},   err_cmd,   m_cmd);
        check({tag, ":err_move"},  err_move,  m_move);
        check({tag, ":err_bound"}, err_bound, m_bound);
        check({tag, ":tour_done"}, tour_done, m_done);
    endtask

    // Entered and left at posedge+1; one command, full handshake
    task automatic handshake(input logic [15:0] c, input bit arm_mid, input string tag);
        int n, lat;
        cmd = c; cmd_rdy = 1'b1; n = 0;
        @(negedge clk);
        while (clr_cmd_rdy !== 1'b1 && n < 8) begin
            @(posedge clk); #1; n++;
            @(negedge clk);
        end
        check({tag, ":accept_cycle"}, n, 0);
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        cmd = 16'($urandom);
        lat = 1;
        if (arm_mid) arm = 1'b1;
        @(negedge clk);
        while (send_resp !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; arm = 1'b0; lat++;
            @(negedge clk);
        end
        check({tag, ":resp_latency"}, lat, EXEC + 1);
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic do_pair(input logic [15:0] h, input logic [15:0] v, input logic [7:0] rsp,
                           input bit arm_mid, input string tag);
        logic [7:0] emv;
        int eidx;
        model_pair(h, v, rsp, emv, eidx);
        handshake(h, arm_mid, {tag, ":H"});
        resp = rsp;
        handshake(v, 1'b0, {tag, ":V"});
        resp = RESP_BUSY;
        @(negedge clk);
        check({tag, ":move_wr"},  move_wr,  1);
        check({tag, ":move_out"}, move_out, emv);
        check({tag, ":log_indx"}, wr_indx,  eidx);
        @(posedge clk); #1;
        check({tag, ":move_wr_low"}, move_wr, 0);
        check_state(tag);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         sends, k, r;
        logic [15:0] h, v;
        logic [7:0]  hd_tab[5];
        logic [7:0]  rsp;

        rst = 1'b1; arm = 1'b0; cmd_rdy = 1'b0; cmd = '0; resp = RESP_BUSY;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        check("reset:clr_cmd_rdy", clr_cmd_rdy, 0);
        check("reset:send_resp",   send_resp,   0);
        check("reset:move_wr",     move_wr,     0);
        check("reset:move_out",    move_out,    0);
        check_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic pair: (+1,+2) from (2,2)
        do_pair(16'h2BF1, 16'h3002, RESP_BUSY, 1'b0, "basic");
        check("basic:move_code", move_out, 0);

        // Vertical first
        do_arm();
        do_pair(16'h3001, 16'h3002, RESP_BUSY, 1'b0, "seq_order");

        // Squares pair {1,1}
        do_arm();
        do_pair(16'h2BF1, 16'h3001, RESP_BUSY, 1'b0, "bad_squares");

        // Walk to (4,2), then step off the east edge
        do_arm();
        do_pair(16'h2BF1, 16'h3002, RESP_BUSY, 1'b0, "to_edge1");
        do_pair(16'h2BF1, 16'h37F2, RESP_BUSY, 1'b0, "to_edge2");
        do_pair(16'h2BF2, 16'h3001, RESP_BUSY, 1'b0, "bound");

        // Reset in the middle of the vertical execution
        do_arm();
        handshake(16'h2BF1, 1'b0, "rst_mid:H");
        cmd = 16'h3002; cmd_rdy = 1'b1;
        @(negedge clk);
        check("rst_mid:V_accept", clr_cmd_rdy, 1);
        @(posedge clk); #1; cmd_rdy = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        sends = 0;
        repeat (12) begin
            @(negedge clk);
            if (send_resp === 1'b1) sends++;
        end
        @(posedge clk); #1;
        check("rst_mid:no_send_resp", sends, 0);
        model_reset();
        check_state("rst_mid");
        do_pair(16'h2BF1, 16'h3002, RESP_BUSY, 1'b0, "after_rst");

        // Full open tour with the end response on the last move
        find_tour(ok);
        check("tour:found", ok, 1);
        do_arm();
        for (int i = 0; i < 24; i++) begin
            do_pair(hcmd(tour_k[i]), vcmd(tour_k[i]), (i == 23) ? RESP_DONE : RESP_BUSY,
                    1'b0, $sformatf("tour%0d", i));
        end
        // Still logged after the tour is done; arm mid-execution is ignored
        do_pair(hcmd(1), vcmd(1), RESP_BUSY, 1'b1, "post_tour");

        // Random pairs
        hd_tab[0] = HDG_E; hd_tab[1] = HDG_W; hd_tab[2] = HDG_N; hd_tab[3] = HDG_S;
        do_arm();
        for (int i = 0; i < 40; i++) begin
            hd_tab[4] = 8'($urandom);
            r = int'($urandom_range(0, 3));
            if (r != 0) begin
                k = int'($urandom_range(0, 7));
                for (int t = 0; t < 16; t++) begin
                    if (m_x + kdx[k] < 0 || m_x + kdx[k] > 4 || m_y + kdy[k] < 0 || m_y + kdy[k] > 4)
                        k = int'($urandom_range(0, 7));
                end
                h = hcmd(k);
                v = vcmd(k);
            end else begin
                h = {($urandom_range(0, 3) == 0) ? 4'($urandom) : OPC_MOVE_A,
                     hd_tab[$urandom_range(0, 4)], 4'($urandom_range(0, 3))};
                v = {($urandom_range(0, 3) == 0) ? 4'($urandom) : OPC_MOVE_B,
                     hd_tab[$urandom_range(0, 4)], 4'($urandom_range(0, 3))};
            end
            rsp = ($urandom_range(0, 7) == 0) ? RESP_DONE : RESP_BUSY;
            do_pair(h, v, rsp, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
            if ($urandom_range(0, 9) == 0) do_arm();
        end

        check("handshake:no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
